// File: rtl/role_dealer_if.sv
// ============================================================================
//  Module   : role_dealer_if
//  Purpose  : Bundles the role dealer's handshake, seed-ROM and result
//             signals so the dealer and its client connect with one port.
//  Ports    : (interface signals)
//             start, ack          client -> dealer command pulses
//             rom_address         dealer -> seed ROM read address
//             rom_data            seed ROM -> dealer (registered, 1-cycle)
//             reveal_*            per-player reveal channel
//             roles, wolf_id,
//             doctor_id           published deal result
//             busy, ready, error  deal status
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface role_dealer_if #(
   parameter int NUM_PLAYERS = 5,
   parameter int NUM_SEEDS   = 20
);
   localparam int AW = $clog2(NUM_SEEDS);
   localparam int PW = $clog2(NUM_PLAYERS);
   localparam int RW = 2 * NUM_PLAYERS;

   logic          start;
   logic          ack;
   logic [AW-1:0] rom_address;
   logic [RW-1:0] rom_data;
   logic          reveal_valid;
   logic [PW-1:0] reveal_player;
   logic [1:0]    reveal_role;
   logic [RW-1:0] roles;
   logic [PW-1:0] wolf_id;
   logic [PW-1:0] doctor_id;
   logic          busy;
   logic          ready;
   logic          error;

   // Client side: issues commands, models the ROM, observes results.
   modport master (
      output start, ack, rom_data,
      input  rom_address, reveal_valid, reveal_player, reveal_role,
             roles, wolf_id, doctor_id, busy, ready, error
   );

   // Dealer side.
   modport slave (
      input  start, ack, rom_data,
      output rom_address, reveal_valid, reveal_player, reveal_role,
             roles, wolf_id, doctor_id, busy, ready, error
   );
endinterface

`default_nettype wire

// File: rtl/role_dealer.sv
// ============================================================================
//  Module   : role_dealer
//  Purpose  : Game-start controller. On start it picks a seed index from a
//             free-running counter, reads the registered seed ROM, validates
//             the role word (falling back to DEFAULT_WORD), reveals each
//             player's role with a per-player ack, then publishes the role
//             word and the decoded wolf/doctor indices.
//  Ports    : clk_i   system clock, all logic on posedge
//             rst_i   synchronous active-high reset
//             bus     role_dealer_if.slave (commands, ROM, reveal, result)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module role_dealer #(
   parameter int                         NUM_PLAYERS  = 5,
   parameter int                         NUM_SEEDS    = 20,
   parameter logic [2*NUM_PLAYERS-1:0]   DEFAULT_WORD = 10'b01_10_00_00_00
) (
   input  logic          clk_i,
   input  logic          rst_i,
   role_dealer_if.slave  bus
);
   localparam int AW = $clog2(NUM_SEEDS);
   localparam int PW = $clog2(NUM_PLAYERS);
   localparam int RW = 2 * NUM_PLAYERS;

   localparam logic [AW-1:0] LAST_SEED = AW'(NUM_SEEDS - 1);
   localparam logic [PW-1:0] LAST_P    = PW'(NUM_PLAYERS - 1);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_REVEAL  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Player 0 occupies the most significant field of the word.
   function automatic logic [1:0] field_of(input logic [RW-1:0] w,
                                           input logic [PW-1:0] idx);
      logic [1:0] f;
      f = 2'b00;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (idx == PW'(i)) f = w[2*(NUM_PLAYERS-1-i) +: 2];
      end
      return f;
   endfunction

   state_t        state_q;
   logic [AW-1:0] seed_cnt_q;
   logic [AW-1:0] rom_address_q;
   logic          reveal_valid_q;
   logic [PW-1:0] reveal_player_q;
   logic [1:0]    reveal_role_q;
   logic [RW-1:0] roles_q;
   logic [PW-1:0] wolf_id_q;
   logic [PW-1:0] doctor_id_q;
   logic          busy_q;
   logic          ready_q;
   logic          error_q;

   // Validation of the incoming ROM word and decode of the word to latch.
   logic [PW:0]   wolf_cnt_d;
   logic [PW:0]   doc_cnt_d;
   logic          bad_field_d;
   logic          word_ok_d;
   logic [RW-1:0] roles_d;
   logic [PW-1:0] wolf_id_d;
   logic [PW-1:0] doctor_id_d;

   always_comb begin
      wolf_cnt_d  = '0;
      doc_cnt_d   = '0;
      bad_field_d = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         case (bus.rom_data[2*(NUM_PLAYERS-1-i) +: 2])
            2'b01:   wolf_cnt_d  = wolf_cnt_d + CNT_ONE;
            2'b10:   doc_cnt_d   = doc_cnt_d + CNT_ONE;
            2'b11:   bad_field_d = 1'b1;
            default: ;
         endcase
      end
      word_ok_d = (wolf_cnt_d == CNT_ONE) && (doc_cnt_d == CNT_ONE) && !bad_field_d;
      roles_d   = word_ok_d ? bus.rom_data : DEFAULT_WORD;

      // IDs come from the word actually latched, so the fallback decodes too.
      wolf_id_d   = '0;
      doctor_id_d = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (roles_d[2*(NUM_PLAYERS-1-i) +: 2] == 2'b01) wolf_id_d   = PW'(i);
         if (roles_d[2*(NUM_PLAYERS-1-i) +: 2] == 2'b10) doctor_id_d = PW'(i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= S_IDLE;
         seed_cnt_q      <= '0;
         rom_address_q   <= '0;
         reveal_valid_q  <= 1'b0;
         reveal_player_q <= '0;
         reveal_role_q   <= 2'b00;
         roles_q         <= '0;
         wolf_id_q       <= '0;
         doctor_id_q     <= '0;
         busy_q          <= 1'b0;
         ready_q         <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         // Free-running seed source; its phase at start picks the ROM entry.
         seed_cnt_q <= (seed_cnt_q == LAST_SEED) ? '0 : seed_cnt_q + 1'b1;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  rom_address_q <= seed_cnt_q;
                  busy_q        <= 1'b1;
                  ready_q       <= 1'b0;
                  error_q       <= 1'b0;
                  state_q       <= S_FETCH;
               end
            end
            S_FETCH: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               roles_q         <= roles_d;
               error_q         <= !word_ok_d;
               wolf_id_q       <= wolf_id_d;
               doctor_id_q     <= doctor_id_d;
               reveal_valid_q  <= 1'b1;
               reveal_player_q <= '0;
               reveal_role_q   <= field_of(roles_d, '0);
               state_q         <= S_REVEAL;
            end
            S_REVEAL: begin
               if (bus.ack) begin
                  if (reveal_player_q != LAST_P) begin
                     reveal_player_q <= reveal_player_q + 1'b1;
                     reveal_role_q   <= field_of(roles_q, reveal_player_q + 1'b1);
                  end else begin
                     reveal_valid_q <= 1'b0;
                     busy_q         <= 1'b0;
                     ready_q        <= 1'b1;
                     state_q        <= S_DONE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.rom_address   = rom_address_q;
   assign bus.reveal_valid  = reveal_valid_q;
   assign bus.reveal_player = reveal_player_q;
   assign bus.reveal_role   = reveal_role_q;
   assign bus.roles         = roles_q;
   assign bus.wolf_id       = wolf_id_q;
   assign bus.doctor_id     = doctor_id_q;
   assign bus.busy          = busy_q;
   assign bus.ready         = ready_q;
   assign bus.error         = error_q;

endmodule

`default_nettype wire
